// File: rtl/pcpi_mac.sv
// PCPI coprocessor: iterative signed 16x16 multiply-accumulate on the custom-0 opcode.
// Define PCPI_MAC_SAT_EN to saturate accumulator read-back to signed 32 bits.
module pcpi_mac #(
    parameter int         ACC_W     = 40,
    parameter int         STEP_BITS = 2,
    parameter logic [6:0] FUNCT7    = 7'b0000001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    localparam int         N      = 16 / STEP_BITS;
    localparam int         CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [6:0] OPCODE = 7'b0001011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MAC    = 2'b00,
        OP_MACRD  = 2'b01,
        OP_MACCLR = 2'b10,
        OP_MUL16  = 2'b11
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [31:0]        mcand_q, mcand_d;
    logic [15:0]        mplier_q, mplier_d;
    logic [31:0]        prod_q, prod_d;
    logic               neg_q, neg_d;
    logic [31:0]        rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               wait_q, wait_d;
    logic               ready_q, ready_d;

    logic               match;
    op_e                insn_op;
    logic [15:0]        a_mag, b_mag;
    logic [31:0]        partial;
    logic signed [31:0] product;
    logic [ACC_W-1:0]   acc_sum;
    logic [31:0]        acc_conv, sum_conv;
    logic               unused_bits;

    // funct3 values 000..011 are exactly those with insn[14] clear.
    assign match   = (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7) && !pcpi_insn[14];
    assign insn_op = op_e'(pcpi_insn[13:12]);

    assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs1[31:16], pcpi_rs2[31:16]};

    // Multiply on magnitudes and fix the sign at the end; |-32768| still fits in 16 bits.
    assign a_mag = pcpi_rs1[15] ? (~pcpi_rs1[15:0] + 16'd1) : pcpi_rs1[15:0];
    assign b_mag = pcpi_rs2[15] ? (~pcpi_rs2[15:0] + 16'd1) : pcpi_rs2[15:0];

    always_comb begin
        partial = '0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
    end

    assign product = neg_q ? (~prod_q + 32'd1) : prod_q;
    assign acc_sum = acc_q + ACC_W'(product);

`ifdef PCPI_MAC_SAT_EN
    function automatic logic [31:0] sat32(input logic [ACC_W-1:0] v);
        logic [ACC_W-32:0] upper;
        upper = v[ACC_W-1:31];
        if (&upper || !(|upper)) begin
            return v[31:0];
        end else if (v[ACC_W-1]) begin
            return 32'h8000_0000;
        end else begin
            return 32'h7fff_ffff;
        end
    endfunction

    assign acc_conv = sat32(acc_q);
    assign sum_conv = sat32(acc_sum);
`else
    assign acc_conv = acc_q[31:0];
    assign sum_conv = acc_sum[31:0];
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        rd_d     = rd_q;
        wr_d     = 1'b0;
        ready_d  = 1'b0;
        wait_d   = wait_q;

        unique case (state_q)
            S_IDLE: begin
                if (pcpi_valid && match) begin
                    op_d = insn_op;
                    if (insn_op == OP_MACRD || insn_op == OP_MACCLR) begin
                        rd_d    = acc_conv;
                        wr_d    = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_DONE;
                        if (insn_op == OP_MACCLR) begin
                            acc_d = '0;
                        end
                    end else begin
                        mcand_d  = {16'd0, a_mag};
                        mplier_d = b_mag;
                        prod_d   = '0;
                        neg_d    = pcpi_rs1[15] ^ pcpi_rs2[15];
                        cnt_d    = CNT_W'(N - 1);
                        wait_d   = 1'b1;
                        state_d  = S_MUL;
                    end
                end
            end

            S_MUL: begin
                if (!pcpi_valid) begin
                    wait_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    prod_d   = prod_q + partial;
                    mcand_d  = mcand_q << STEP_BITS;
                    mplier_d = mplier_q >> STEP_BITS;
                    if (cnt_q == '0) begin
                        state_d = S_ACC;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            S_ACC: begin
                wait_d  = 1'b0;
                state_d = S_IDLE;
                if (pcpi_valid) begin
                    wr_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                    if (op_q == OP_MAC) begin
                        acc_d = acc_sum;
                        rd_d  = sum_conv;
                    end else begin
                        rd_d  = product;
                    end
                end
            end

            // The CPU still holds valid here; ignoring it keeps the finished instruction from restarting.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MAC;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            wait_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wait_q   <= wait_d;
            ready_q  <= ready_d;
        end
    end

    assign pcpi_wr    = wr_q;
    assign pcpi_rd    = rd_q;
    assign pcpi_wait  = wait_q;
    assign pcpi_ready = ready_q;

endmodule

// File: tb/tb_pcpi_mac.sv
// Directed bench for pcpi_mac with default parameters; build with PCPI_MAC_SAT_EN to check saturation.
module tb_pcpi_mac;

    localparam logic [6:0] OPC  = 7'b0001011;
    localparam logic [6:0] F7   = 7'b0000001;
`ifdef PCPI_MAC_SAT_EN
    localparam logic [31:0] EXP_BIG = 32'h7fff_ffff;
`else
    localparam logic [31:0] EXP_BIG = 32'hbffd_0003;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = '0;
    logic [31:0] pcpi_rs1 = '0;
    logic [31:0] pcpi_rs2 = '0;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int passed = 0;
    int total  = 0;

    pcpi_mac dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Offers one instruction and holds valid through the edge after ready; cycle k is the k-th cycle after capture.
    task automatic run_insn(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rd, output logic wr_seen,
                            output int rdy_cyc, output int wfirst, output int wlast);
        @(negedge clk);
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        rd = '0; wr_seen = 1'b0; rdy_cyc = -1; wfirst = -1; wlast = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pcpi_wait) begin
                if (wfirst < 0) wfirst = k;
                wlast = k;
            end
            if (pcpi_ready) begin
                rdy_cyc = k;
                rd      = pcpi_rd;
                wr_seen = pcpi_wr;
                break;
            end
        end
        @(posedge clk);
        #1;
        pcpi_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pcpi_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", pcpi_wr); else passed++;
        total++; if (pcpi_rd !== 32'h0) $display("FAIL reset_rd: got %h want 00000000", pcpi_rd); else passed++;
        total++; if (pcpi_wait !== 1'b0) $display("FAIL reset_wait: got %b want 0", pcpi_wait); else passed++;
        total++; if (pcpi_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", pcpi_ready); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_macclr();
        logic [31:0] rd; logic wr; int rc, wf, wl;
        run_insn(mk_insn(F7, 3'b010, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rc !== 1) $display("FAIL macclr_latency: got %0d want 1", rc); else passed++;
        total++; if (wr !== 1'b1) $display("FAIL macclr_wr: got %b want 1", wr); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL macclr_rd: got %h want 00000000", rd); else passed++;
        total++; if (wf !== -1) $display("FAIL macclr_wait: first wait cycle %0d want none", wf); else passed++;
    endtask

    task automatic test_mac();
        logic [31:0] rd; logic wr; int rc, wf, wl;
        run_insn(mk_insn(F7, 3'b000, OPC), 32'h0000_0003, 32'hffff_fffe, rd, wr, rc, wf, wl);
        total++; if (rc !== 10) $display("FAIL mac_latency: got %0d want 10", rc); else passed++;
        total++; if (wf !== 1) $display("FAIL mac_wait_first: got %0d want 1", wf); else passed++;
        total++; if (wl !== 9) $display("FAIL mac_wait_last: got %0d want 9", wl); else passed++;
        total++; if (wr !== 1'b1) $display("FAIL mac_wr: got %b want 1", wr); else passed++;
        total++; if (rd !== 32'hffff_fffa) $display("FAIL mac_rd: got %h want fffffffa", rd); else passed++;
        run_insn(mk_insn(F7, 3'b001, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rc !== 1) $display("FAIL macrd_latency: got %0d want 1", rc); else passed++;
        total++; if (rd !== 32'hffff_fffa) $display("FAIL macrd_after_mac: got %h want fffffffa", rd); else passed++;
    endtask

    task automatic test_mul16();
        logic [31:0] rd; logic wr; int rc, wf, wl;
        run_insn(mk_insn(F7, 3'b011, OPC), 32'h1234_8000, 32'habcd_8000, rd, wr, rc, wf, wl);
        total++; if (rc !== 10) $display("FAIL mul16_latency: got %0d want 10", rc); else passed++;
        total++; if (rd !== 32'h4000_0000) $display("FAIL mul16_rd: got %h want 40000000", rd); else passed++;
        run_insn(mk_insn(F7, 3'b011, OPC), 32'h0000_7fff, 32'h0000_8000, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'hc000_8000) $display("FAIL mul16_mixed_rd: got %h want c0008000", rd); else passed++;
        run_insn(mk_insn(F7, 3'b001, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'hffff_fffa) $display("FAIL macrd_after_mul16: got %h want fffffffa", rd); else passed++;
    endtask

    task automatic test_saturation();
        logic [31:0] rd; logic wr; int rc, wf, wl;
        run_insn(mk_insn(F7, 3'b010, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'hffff_fffa) $display("FAIL macclr_old_acc: got %h want fffffffa", rd); else passed++;
        run_insn(mk_insn(F7, 3'b000, OPC), 32'h0000_7fff, 32'h0000_7fff, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'h3fff_0001) $display("FAIL sat_mac1: got %h want 3fff0001", rd); else passed++;
        run_insn(mk_insn(F7, 3'b000, OPC), 32'h0000_7fff, 32'h0000_7fff, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'h7ffe_0002) $display("FAIL sat_mac2: got %h want 7ffe0002", rd); else passed++;
        run_insn(mk_insn(F7, 3'b000, OPC), 32'h0000_7fff, 32'h0000_7fff, rd, wr, rc, wf, wl);
        total++; if (rd !== EXP_BIG) $display("FAIL sat_mac3: got %h want %h", rd, EXP_BIG); else passed++;
        run_insn(mk_insn(F7, 3'b001, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rd !== EXP_BIG) $display("FAIL sat_macrd: got %h want %h", rd, EXP_BIG); else passed++;
    endtask

    task automatic test_nomatch();
        logic [31:0] insns [3];
        int hits;
        insns[0] = mk_insn(7'b0000001, 3'b000, 7'b0110011);
        insns[1] = mk_insn(F7, 3'b100, OPC);
        insns[2] = mk_insn(7'b0000000, 3'b000, OPC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pcpi_insn  = insns[i];
            pcpi_rs1   = 32'h5;
            pcpi_rs2   = 32'h7;
            pcpi_valid = 1'b1;
            hits = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (pcpi_wait || pcpi_ready) hits++;
            end
            pcpi_valid = 1'b0;
            total++; if (hits !== 0) $display("FAIL nomatch_%0d: %0d cycles with wait/ready, want 0", i, hits); else passed++;
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic wr; int rc, wf, wl; int hits;
        @(negedge clk);
        pcpi_insn  = mk_insn(F7, 3'b000, OPC);
        pcpi_rs1   = 32'h1;
        pcpi_rs2   = 32'h1;
        pcpi_valid = 1'b1;
        repeat (5) @(negedge clk);
        pcpi_valid = 1'b0;
        @(negedge clk);
        total++; if (pcpi_wait !== 1'b0) $display("FAIL abort_wait: got %b want 0", pcpi_wait); else passed++;
        hits = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (pcpi_ready) hits++;
        end
        total++; if (hits !== 0) $display("FAIL abort_ready: %0d ready cycles, want 0", hits); else passed++;
        run_insn(mk_insn(F7, 3'b001, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rd !== EXP_BIG) $display("FAIL abort_acc_kept: got %h want %h", rd, EXP_BIG); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic wr; int rc, wf, wl; int hits;
        @(negedge clk);
        pcpi_insn  = mk_insn(F7, 3'b000, OPC);
        pcpi_rs1   = 32'h5;
        pcpi_rs2   = 32'h5;
        pcpi_valid = 1'b1;
        repeat (4) @(negedge clk);
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        @(negedge clk);
        total++; if (pcpi_wait !== 1'b0) $display("FAIL rstmid_wait: got %b want 0", pcpi_wait); else passed++;
        resetn = 1'b1;
        hits = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (pcpi_ready) hits++;
        end
        total++; if (hits !== 0) $display("FAIL rstmid_ready: %0d ready cycles, want 0", hits); else passed++;
        run_insn(mk_insn(F7, 3'b001, OPC), 32'h0, 32'h0, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'h0) $display("FAIL rstmid_acc: got %h want 00000000", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic wr; int rc, wf, wl;
        run_insn(mk_insn(F7, 3'b000, OPC), 32'h0000_0002, 32'h0000_0003, rd, wr, rc, wf, wl);
        total++; if (rd !== 32'h6) $display("FAIL b2b_first_rd: got %h want 00000006", rd); else passed++;
        total++; if (pcpi_wait !== 1'b0) $display("FAIL b2b_no_retrigger: wait %b want 0", pcpi_wait); else passed++;
        total++; if (pcpi_rd !== 32'h6) $display("FAIL b2b_rd_hold: got %h want 00000006", pcpi_rd); else passed++;
        run_insn(mk_insn(F7, 3'b000, OPC), 32'h0000_0004, 32'hffff_fffb, rd, wr, rc, wf, wl);
        total++; if (rc !== 10) $display("FAIL b2b_second_latency: got %0d want 10", rc); else passed++;
        total++; if (rd !== 32'hffff_fff2) $display("FAIL b2b_second_rd: got %h want fffffff2", rd); else passed++;
    endtask

    initial begin
        test_reset();
        test_macclr();
        test_mac();
        test_mul16();
        test_saturation();
        test_nomatch();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
